// File: rtl/sprite_pkg.sv
// Shared types and sizing for the sprite list buffer and its banks.
package sprite_pkg;

  localparam int CANVAS_WIDTH  = 100;
  localparam int CANVAS_HEIGHT = 100;
  localparam int NUM_FRAMES    = 100;
  localparam int MAX_SPRITES   = 32;

  localparam int XW = $clog2(CANVAS_WIDTH);
  localparam int YW = $clog2(CANVAS_HEIGHT);
  localparam int FW = $clog2(NUM_FRAMES);
  localparam int CW = $clog2(MAX_SPRITES + 1);
  localparam int AW = $clog2(MAX_SPRITES);
  localparam int SW = XW + YW + FW;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [FW-1:0] frame;
  } sprite_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } read_state_t;

endpackage

// File: rtl/sprite_bank.sv
// One list bank: register array with a synchronous write port and a
// combinational read port. Contents need no reset; validity is tracked
// by the entry counters in the top.
module sprite_bank import sprite_pkg::*; #(
  parameter int DEPTH = MAX_SPRITES,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              pixel_clk_in,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [SW-1:0]     wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [SW-1:0]     rdata
);

  sprite_t mem [DEPTH];

  // Store one sprite per accepted write.
  always_ff @(posedge pixel_clk_in) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_list_buffer.sv
// Collects emitted sprites per frame into ping-pong banks and replays the
// last completed frame's list over a valid/ready stream.
//
// state  | meaning
// IDLE   | no replay in progress, waiting for rd_start
// STREAM | presenting committed entries to the renderer
module sprite_list_buffer import sprite_pkg::*; (
  input  logic          pixel_clk_in,
  input  logic          rst_in,
  input  logic          new_frame,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [FW-1:0] frame,
  input  logic          sprite_valid,
  input  logic          rd_start,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [FW-1:0] out_frame,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          rd_done,
  output logic          rd_abort,
  output logic [CW-1:0] sprite_count,
  output logic          overflow
);

  logic          wr_bank;
  logic [CW-1:0] wr_count;
  logic          wr_ovf;
  logic          accept;
  logic          drop;
  sprite_t       wr_data;
  sprite_t       rd_data;
  logic [SW-1:0] rd_data_0;
  logic [SW-1:0] rd_data_1;
  logic [AW-1:0] rd_addr;

  read_state_t   state_q, state_d;
  sprite_t       out_q, out_d;
  logic          valid_d;
  logic [AW-1:0] rd_idx, idx_d;
  logic          done_d, abort_d;

  assign accept  = sprite_valid && (wr_count < CW'(MAX_SPRITES));
  assign drop    = sprite_valid && !accept;
  assign wr_data = {x, y, frame};

  sprite_bank #(.DEPTH(MAX_SPRITES)) u_bank_0 (
    .pixel_clk_in (pixel_clk_in),
    .we           (accept && !wr_bank),
    .waddr        (wr_count[AW-1:0]),
    .wdata        (wr_data),
    .raddr        (rd_addr),
    .rdata        (rd_data_0)
  );

  sprite_bank #(.DEPTH(MAX_SPRITES)) u_bank_1 (
    .pixel_clk_in (pixel_clk_in),
    .we           (accept && wr_bank),
    .waddr        (wr_count[AW-1:0]),
    .wdata        (wr_data),
    .raddr        (rd_addr),
    .rdata        (rd_data_1)
  );

  // The committed bank is always the one not being written.
  assign rd_data = wr_bank ? rd_data_0 : rd_data_1;

  // IDLE fetches entry 0 for a fresh replay; STREAM prefetches the next one.
  assign rd_addr = (state_q == STREAM) ? rd_idx + AW'(1) : '0;

  // Write-side counting and the frame swap; a coincident sprite closes the old frame.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_bank      <= 1'b0;
      wr_count     <= '0;
      wr_ovf       <= 1'b0;
      sprite_count <= '0;
      overflow     <= 1'b0;
    end else if (new_frame) begin
      wr_bank      <= !wr_bank;
      wr_count     <= '0;
      wr_ovf       <= 1'b0;
      sprite_count <= wr_count + CW'(accept);
      overflow     <= wr_ovf || drop;
    end else begin
      if (accept) wr_count <= wr_count + CW'(1);
      if (drop)   wr_ovf   <= 1'b1;
    end
  end

  // Read FSM registers and registered stream outputs.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      out_q     <= '0;
      out_valid <= 1'b0;
      rd_idx    <= '0;
      rd_done   <= 1'b0;
      rd_abort  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      out_valid <= valid_d;
      rd_idx    <= idx_d;
      rd_done   <= done_d;
      rd_abort  <= abort_d;
    end
  end

  // Next-state and next-output logic; a frame swap always wins over replay.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    valid_d = out_valid;
    idx_d   = rd_idx;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (rd_start && !new_frame) begin
          if (sprite_count == '0) begin
            done_d = 1'b1;
          end else begin
            out_d   = rd_data;
            valid_d = 1'b1;
            idx_d   = '0;
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (new_frame) begin
          valid_d = 1'b0;
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (out_valid && out_ready) begin
          if (out_last) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            out_d = rd_data;
            idx_d = rd_idx + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_last  = out_valid && (CW'(rd_idx) == sprite_count - CW'(1));
  assign out_x     = out_q.x;
  assign out_y     = out_q.y;
  assign out_frame = out_q.frame;

endmodule

// File: tb/tb_sprite_list_buffer.sv
// Self-checking bench for sprite_list_buffer against a queue-based list model.
module tb_sprite_list_buffer;
  import sprite_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, new_frame, sprite_valid, rd_start, out_ready;
  logic [XW-1:0] x, out_x;
  logic [YW-1:0] y, out_y;
  logic [FW-1:0] frame, out_frame;
  logic          out_valid, out_last, rd_done, rd_abort, overflow;
  logic [CW-1:0] sprite_count;

  int n_cmp = 0;
  int n_bad = 0;

  sprite_t wq[$];
  sprite_t cq[$];
  bit      m_wovf, m_ovf;

  sprite_list_buffer dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .new_frame    (new_frame),
    .x            (x),
    .y            (y),
    .frame        (frame),
    .sprite_valid (sprite_valid),
    .rd_start     (rd_start),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_frame    (out_frame),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .rd_done      (rd_done),
    .rd_abort     (rd_abort),
    .sprite_count (sprite_count),
    .overflow     (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a frame's list is every sprite seen until new_frame, capped at MAX_SPRITES.
  task automatic clock_model();
    sprite_t s;
    if (sprite_valid) begin
      s.x = x; s.y = y; s.frame = frame;
      if (wq.size() < MAX_SPRITES) wq.push_back(s);
      else m_wovf = 1'b1;
    end
    if (new_frame) begin
      cq = wq;
      m_ovf = m_wovf;
      wq.delete();
      m_wovf = 1'b0;
    end
    tick();
  endtask

  task automatic model_reset();
    wq.delete();
    cq.delete();
    m_wovf = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic drive_sprite(input int sx, input int sy, input int sf);
    x = XW'(sx); y = YW'(sy); frame = FW'(sf);
    sprite_valid = 1'b1;
    clock_model();
    sprite_valid = 1'b0;
  endtask

  task automatic drive_random(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) clock_model();
      drive_sprite($urandom_range(0, CANVAS_WIDTH-1), $urandom_range(0, CANVAS_HEIGHT-1),
                   $urandom_range(0, NUM_FRAMES-1));
    end
  endtask

  task automatic commit(input string tag, input bit with_sprite);
    if (with_sprite) begin
      x = XW'($urandom_range(0, CANVAS_WIDTH-1));
      y = YW'($urandom_range(0, CANVAS_HEIGHT-1));
      frame = FW'($urandom_range(0, NUM_FRAMES-1));
      sprite_valid = 1'b1;
    end
    new_frame = 1'b1;
    clock_model();
    new_frame = 1'b0;
    sprite_valid = 1'b0;
    n_cmp++;
    if (sprite_count !== CW'(cq.size())) begin
      n_bad++;
      $display("FAIL %s_count: got %0d want %0d", tag, sprite_count, cq.size());
    end
    n_cmp++;
    if (overflow !== m_ovf) begin
      n_bad++;
      $display("FAIL %s_overflow: got %0b want %0b", tag, overflow, m_ovf);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1 repeating
  task automatic replay(input int mode, input string tag);
    int k = 0;
    int n = cq.size();
    int cyc = 0;
    bit rdy;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    rd_start = 1'b1;
    out_ready = 1'b0;
    clock_model();
    rd_start = 1'b0;
    while (k < n && cyc < 400) begin
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_valid[%0d]: got %0b want 1", tag, k, out_valid);
      end
      n_cmp++;
      if ({out_x, out_y, out_frame} !== cq[k]) begin
        n_bad++;
        $display("FAIL %s_data[%0d]: got %0d,%0d,%0d want %0d,%0d,%0d", tag, k,
                 out_x, out_y, out_frame, cq[k].x, cq[k].y, cq[k].frame);
      end
      n_cmp++;
      if (out_last !== (k == n-1)) begin
        n_bad++;
        $display("FAIL %s_last[%0d]: got %0b want %0b", tag, k, out_last, (k == n-1));
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: rdy = pat[cyc % 4];
      endcase
      out_ready = rdy;
      clock_model();
      if (rdy) k++;
      cyc++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (k != n) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d entries want %0d", tag, k, n);
    end
    n_cmp++;
    if (rd_done !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done: got done=%0b valid=%0b want done=1 valid=0", tag, rd_done, out_valid);
    end
    tick();
    n_cmp++;
    if (rd_done !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done_pulse: got done=%0b valid=%0b want 0 0", tag, rd_done, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({out_valid, out_last, rd_done, rd_abort, overflow} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000", {out_valid, out_last, rd_done, rd_abort, overflow});
    end
    n_cmp++;
    if (sprite_count !== '0 || {out_x, out_y, out_frame} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got count=%0d data=%0h want 0 0", sprite_count, {out_x, out_y, out_frame});
    end
    model_reset();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    drive_sprite(10, 20, 1);
    drive_sprite(30, 40, 2);
    drive_sprite(50, 60, 3);
    commit("t1", 1'b0);
    replay(0, "t1");
  endtask

  task automatic test_empty();
    commit("t2", 1'b0);
    replay(0, "t2");
  endtask

  task automatic test_overflow();
    drive_random(34);
    commit("t3a", 1'b0);
    replay(1, "t3a");
    drive_random(1);
    commit("t3b", 1'b0);
    replay(0, "t3b");
  endtask

  task automatic test_stall();
    drive_random(5);
    commit("t4", 1'b0);
    replay(2, "t4");
  endtask

  task automatic test_abort();
    drive_random(5);
    commit("t5a", 1'b0);
    drive_random(3);
    rd_start = 1'b1;
    clock_model();
    rd_start = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || {out_x, out_y, out_frame} !== cq[k]) begin
        n_bad++;
        $display("FAIL t5_pre[%0d]: got valid=%0b data=%0h want 1 %0h", k, out_valid,
                 {out_x, out_y, out_frame}, cq[k]);
      end
      if (k < 2) clock_model();
    end
    out_ready = 1'b0;
    new_frame = 1'b1;
    clock_model();
    new_frame = 1'b0;
    n_cmp++;
    if ({rd_abort, out_valid, rd_done} !== 3'b100) begin
      n_bad++;
      $display("FAIL t5_abort: got abort,valid,done=%b want 100", {rd_abort, out_valid, rd_done});
    end
    n_cmp++;
    if (sprite_count !== CW'(3)) begin
      n_bad++;
      $display("FAIL t5_count: got %0d want 3", sprite_count);
    end
    tick();
    n_cmp++;
    if ({rd_abort, out_valid, rd_done} !== 3'b000) begin
      n_bad++;
      $display("FAIL t5_abort_pulse: got abort,valid,done=%b want 000", {rd_abort, out_valid, rd_done});
    end
    replay(0, "t5b");
    rd_start = 1'b1;
    new_frame = 1'b1;
    clock_model();
    rd_start = 1'b0;
    new_frame = 1'b0;
    n_cmp++;
    if ({out_valid, rd_done, sprite_count} !== {2'b00, CW'(0)}) begin
      n_bad++;
      $display("FAIL t5_start_vs_swap: got valid=%0b done=%0b count=%0d want 0 0 0",
               out_valid, rd_done, sprite_count);
    end
  endtask

  task automatic test_coincident();
    drive_random(2);
    commit("t6a", 1'b1);
    replay(1, "t6a");
    commit("t6b", 1'b0);
    replay(0, "t6b");
  endtask

  task automatic test_reset_mid();
    drive_random(3);
    commit("t7", 1'b0);
    rd_start = 1'b1;
    clock_model();
    rd_start = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL t7_streaming: got valid=%0b want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, sprite_count, overflow} !== '0) begin
      n_bad++;
      $display("FAIL t7_async_reset: got valid=%0b count=%0d ovf=%0b want 0 0 0",
               out_valid, sprite_count, overflow);
    end
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    replay(0, "t7");
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      drive_random($urandom_range(0, 36));
      commit("rnd", 1'($urandom_range(0, 1)));
      replay(1, "rnd");
    end
  endtask

  initial begin
    rst = 1'b1;
    new_frame = 1'b0;
    sprite_valid = 1'b0;
    rd_start = 1'b0;
    out_ready = 1'b0;
    x = '0; y = '0; frame = '0;
    model_reset();
    test_reset();
    test_basic();
    test_empty();
    test_overflow();
    test_stall();
    test_abort();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
